// File: rtl/disp_mux.sv
// Time-multiplexed common-anode 7-segment driver: scans N_DIG digits with one dead cycle per slot.
// Optional blink support is compiled in with `define DISP_BLINK_EN (adds the blink_mask port).
module disp_mux #(
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_EN      = 0,
    parameter int BLINK_DIV   = 256,
    localparam int IDX_W      = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [4*N_DIG-1:0] digits,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic [N_DIG-1:0]   blank,
`ifdef DISP_BLINK_EN
    input  logic [N_DIG-1:0]   blink_mask,
`endif
    output logic [6:0]         seg,
    output logic               dp,
    output logic [N_DIG-1:0]   an,
    output logic [IDX_W-1:0]   dig_idx
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [IDX_W-1:0] idx_next;
    logic [N_DIG-1:0] an_next;
    logic [N_DIG-1:0] blank_eff;
    logic [3:0]       nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = (HEX_EN != 0) ? 7'b0001000 : 7'b0111111;
            4'hB: s = (HEX_EN != 0) ? 7'b0000011 : 7'b0111111;
            4'hC: s = (HEX_EN != 0) ? 7'b1000110 : 7'b0111111;
            4'hD: s = (HEX_EN != 0) ? 7'b0100001 : 7'b0111111;
            4'hE: s = (HEX_EN != 0) ? 7'b0000110 : 7'b0111111;
            default: s = (HEX_EN != 0) ? 7'b0001110 : 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_next = (dig_idx == IDX_W'(N_DIG - 1)) ? '0 : dig_idx + IDX_W'(1);
    assign nib      = digits[4*dig_idx +: 4];

    always_comb begin
        an_next = '1;
        for (int k = 0; k < N_DIG; k++) begin
            an_next[k] = (dig_idx != IDX_W'(k));
        end
    end

`ifdef DISP_BLINK_EN
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FRM_W-1:0] frame_cnt;
    logic             phase_on;

    // Frame counter: one count per completed scan (tick on the last digit)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (tick && (dig_idx == IDX_W'(N_DIG - 1))) begin
            if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    assign blank_eff = blank | (phase_on ? '0 : blink_mask);
`else
    assign blank_eff = blank;
`endif

    // Output stage: tick edge produces the dead cycle, other edges drive the active digit
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            dig_idx <= '0;
            an      <= '1;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else if (tick) begin
            cnt     <= '0;
            dig_idx <= idx_next;
            an      <= '1;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            an      <= an_next;
            seg     <= blank_eff[dig_idx] ? 7'h7F : decode(nib);
            dp      <= blank_eff[dig_idx] | ~dp_in[dig_idx];
        end
    end

endmodule

// File: tb/tb_disp_mux.sv
// Directed bench for disp_mux: 4-digit plain and hex instances plus a single-digit instance.
// Blink scenario is compiled only when DISP_BLINK_EN is defined.
module tb_disp_mux;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  digits1 = 4'h7;
    logic        dp_in1 = 1'b1;
    logic        blank1 = 1'b0;
    logic        blink1 = 1'b0;

    logic [6:0]  seg, seg_h, seg1;
    logic        dp, dp_h, dp1;
    logic [3:0]  an, an_h;
    logic        an1;
    logic [1:0]  idx, idx_h;
    logic        idx1;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    disp_mux #(.N_DIG(4), .REFRESH_DIV(4), .HEX_EN(0), .BLINK_DIV(2)) dut (
        .CLK(CLK), .RESET(RESET), .digits(digits), .dp_in(dp_in), .blank(blank),
`ifdef DISP_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .dp(dp), .an(an), .dig_idx(idx));

    disp_mux #(.N_DIG(4), .REFRESH_DIV(4), .HEX_EN(1), .BLINK_DIV(2)) dut_hex (
        .CLK(CLK), .RESET(RESET), .digits(digits), .dp_in(dp_in), .blank(blank),
`ifdef DISP_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg_h), .dp(dp_h), .an(an_h), .dig_idx(idx_h));

    disp_mux #(.N_DIG(1), .REFRESH_DIV(4), .HEX_EN(0), .BLINK_DIV(2)) dut1 (
        .CLK(CLK), .RESET(RESET), .digits(digits1), .dp_in(dp_in1), .blank(blank1),
`ifdef DISP_BLINK_EN
        .blink_mask(blink1),
`endif
        .seg(seg1), .dp(dp1), .an(an1), .dig_idx(idx1));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge CLK);
        #3 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic test_reset();
        digits = 16'h1234; blank = 4'h0; dp_in = 4'h0;
        reset_dut();
        for (int s = 0; s < 6; s++) step();
        #3 RESET = 1'b1;
        #1;
        vecs++;
        if ({seg, dp, an, idx} !== {7'h7F, 1'b1, 4'hF, 2'd0}) begin
            errs++;
            $display("FAIL reset_async seg=%b dp=%b an=%b idx=%0d want seg=1111111 dp=1 an=1111 idx=0",
                     seg, dp, an, idx);
        end
        @(posedge CLK);
        #1 RESET = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            logic [3:0] ean;
            logic [1:0] eidx;
            step();
            ean  = (s % 4 == 0) ? 4'hF : ((s < 4) ? 4'b1110 : 4'b1101);
            eidx = (s < 4) ? 2'd0 : 2'd1;
            vecs++;
            if (an !== ean || idx !== eidx) begin
                errs++;
                $display("FAIL reset_restart s=%0d an=%b idx=%0d want an=%b idx=%0d", s, an, idx, ean, eidx);
            end
        end
    endtask

    task automatic test_scan();
        logic [27:0] tbl;
        tbl = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        digits = 16'h1234; blank = 4'h0; dp_in = 4'h0;
        reset_dut();
        for (int s = 1; s <= 32; s++) begin
            int d;
            logic [3:0] ean;
            logic [6:0] eseg;
            step();
            d    = (s / 4) % 4;
            ean  = (s % 4 == 0) ? 4'hF : ~(4'b0001 << d);
            eseg = (s % 4 == 0) ? 7'h7F : tbl[7*d +: 7];
            vecs++;
            if (an !== ean || seg !== eseg || dp !== 1'b1 || idx !== 2'(d)) begin
                errs++;
                $display("FAIL scan s=%0d an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=1 idx=%0d",
                         s, an, seg, dp, idx, ean, eseg, d);
            end
        end
    endtask

    task automatic test_hex();
        logic [27:0] tbl;
        tbl = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
        digits = 16'hABCD; blank = 4'h0; dp_in = 4'h0;
        reset_dut();
        for (int s = 1; s <= 16; s++) begin
            int d;
            logic [6:0] edash, ehex;
            step();
            d     = (s / 4) % 4;
            edash = (s % 4 == 0) ? 7'h7F : 7'b0111111;
            ehex  = (s % 4 == 0) ? 7'h7F : tbl[7*d +: 7];
            vecs++;
            if (seg !== edash) begin
                errs++;
                $display("FAIL hex_off s=%0d seg=%b want %b", s, seg, edash);
            end
            vecs++;
            if (seg_h !== ehex) begin
                errs++;
                $display("FAIL hex_on s=%0d seg=%b want %b", s, seg_h, ehex);
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [27:0] tbl;
        tbl = {7'b1111001, 7'h7F, 7'b0110000, 7'b0011001};
        digits = 16'h1234; blank = 4'b0100; dp_in = 4'b0001;
        reset_dut();
        for (int s = 1; s <= 16; s++) begin
            int d;
            logic [3:0] ean;
            logic [6:0] eseg;
            logic       edp;
            step();
            d    = (s / 4) % 4;
            ean  = (s % 4 == 0) ? 4'hF : ~(4'b0001 << d);
            eseg = (s % 4 == 0) ? 7'h7F : tbl[7*d +: 7];
            edp  = !((s % 4 != 0) && d == 0);
            vecs++;
            if (an !== ean || seg !== eseg || dp !== edp) begin
                errs++;
                $display("FAIL blank_dp s=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         s, an, seg, dp, ean, eseg, edp);
            end
        end
    endtask

    task automatic test_change();
        digits = 16'h0000; blank = 4'h0; dp_in = 4'h0;
        reset_dut();
        step();
        vecs++;
        if (seg !== 7'b1000000 || an !== 4'b1110) begin
            errs++;
            $display("FAIL change_before seg=%b an=%b want seg=1000000 an=1110", seg, an);
        end
        digits[3:0] = 4'h8;
        #1;
        vecs++;
        if (seg !== 7'b1000000) begin
            errs++;
            $display("FAIL change_early seg=%b want 1000000", seg);
        end
        step();
        vecs++;
        if (seg !== 7'b0000000 || an !== 4'b1110) begin
            errs++;
            $display("FAIL change_after seg=%b an=%b want seg=0000000 an=1110", seg, an);
        end
    endtask

    task automatic test_single_digit();
        digits1 = 4'h7; dp_in1 = 1'b1; blank1 = 1'b0;
        reset_dut();
        for (int s = 1; s <= 12; s++) begin
            logic       dead;
            logic [6:0] eseg;
            step();
            dead = (s % 4 == 0);
            eseg = dead ? 7'h7F : 7'b1111000;
            vecs++;
            if (an1 !== dead || seg1 !== eseg || dp1 !== dead || idx1 !== 1'b0) begin
                errs++;
                $display("FAIL single s=%0d an=%b seg=%b dp=%b idx=%0d want an=%b seg=%b dp=%b idx=0",
                         s, an1, seg1, dp1, idx1, dead, eseg, dead);
            end
        end
    endtask

`ifdef DISP_BLINK_EN
    task automatic test_blink();
        logic [27:0] tbl;
        tbl = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        digits = 16'h1234; blank = 4'h0; dp_in = 4'h0; blink_mask = 4'b0001;
        reset_dut();
        for (int s = 1; s <= 128; s++) begin
            int d;
            logic [6:0] eseg;
            step();
            d    = (s / 4) % 4;
            eseg = (s % 4 == 0) ? 7'h7F : tbl[7*d +: 7];
            if (d == 0 && ((s / 32) % 2) == 1) eseg = 7'h7F;
            vecs++;
            if (seg !== eseg) begin
                errs++;
                $display("FAIL blink s=%0d seg=%b want %b", s, seg, eseg);
            end
        end
        blink_mask = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_hex();
        test_blank_dp();
        test_change();
        test_single_digit();
`ifdef DISP_BLINK_EN
        test_blink();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
